// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, ExcCodes.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   // SR fields
   localparam int SR_IE     = 0;
   localparam int SR_EXL    = 1;
   localparam int SR_IM_LO  = 10;
   localparam int SR_IM_HI  = 15;

   // Cause fields
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_t;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: evaluates the M-stage instruction against
// pending interrupts/exceptions, raises req (flush + redirect), and holds
// SR/Cause/EPC/PRId for mfc0/mtc0 and eret.
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  hwint,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [4:0]  exc_code_m,
   input  logic        eret_m,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        req,
   output logic [31:0] next_pc,
   output logic [31:0] epc_out
);

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:2] epc;

   logic        int_req;
   logic        exc_req;
   logic [4:0]  code;
   logic [31:0] epc_new;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   // Request decision uses the pre-write SR, so an mtc0 enabling IE only acts next cycle.
   always_comb begin
      int_req = sr_ie & ~sr_exl & (|(hwint & sr_im));
      exc_req = ~sr_exl & (exc_code_m != 5'd0);
      req     = int_req | exc_req;
      code    = int_req ? EXC_INT : exc_code_m;
      epc_new = bd_m ? (pc_m - 32'd4) : pc_m;
   end

   // CP0 state: exception capture, eret, mtc0, and unconditional IP sampling.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip <= hwint;
         if (req) begin
            sr_exl    <= 1'b1;
            cause_bd  <= bd_m;
            cause_exc <= code;
            epc       <= epc_new[31:2];
         end else begin
            if (eret_m)
               sr_exl <= 1'b0;
            // An mtc0 to SR in the same cycle as eret takes precedence over the eret clear.
            if (cp0_we) begin
               case (cp0_addr)
                  REG_SR: begin
                     sr_im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                     sr_exl <= cp0_wdata[SR_EXL];
                     sr_ie  <= cp0_wdata[SR_IE];
                  end
                  REG_EPC: epc <= cp0_wdata[31:2];
                  default: ;
               endcase
            end
         end
      end
   end

   // Register read mux and fetch redirect target.
   always_comb begin
      sr_word                             = '0;
      sr_word[SR_IM_HI:SR_IM_LO]          = sr_im;
      sr_word[SR_EXL]                     = sr_exl;
      sr_word[SR_IE]                      = sr_ie;
      cause_word                          = '0;
      cause_word[CAUSE_BD]                = cause_bd;
      cause_word[CAUSE_IP_HI:CAUSE_IP_LO] = cause_ip;
      cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
      case (cp0_addr)
         REG_SR:    cp0_rdata = sr_word;
         REG_CAUSE: cp0_rdata = cause_word;
         REG_EPC:   cp0_rdata = {epc, 2'b00};
         REG_PRID:  cp0_rdata = PRID_VAL;
         default:   cp0_rdata = '0;
      endcase
      epc_out = {epc, 2'b00};
      next_pc = req ? HANDLER_PC : {epc, 2'b00};
   end

endmodule
